// File: rtl/fifo_uart_tx_if.sv
// Read-port and serial-line bundle between a first-word-fall-through FIFO
// and the UART transmitter that drains it.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             ENABLE;
  logic             FIFO_EMPTY;
  logic             FIFO_READ;
  logic [WIDTH-1:0] FIFO_RDATA;
  logic             TX;
  logic             BUSY;
  logic             DONE;

  // Transmitter side: issues pops, drives the serial line and status.
  modport master (
    input  ENABLE,
    input  FIFO_EMPTY,
    input  FIFO_RDATA,
    output FIFO_READ,
    output TX,
    output BUSY,
    output DONE
  );

  // FIFO / system side: supplies data and enable, observes the line.
  modport slave (
    output ENABLE,
    output FIFO_EMPTY,
    output FIFO_RDATA,
    input  FIFO_READ,
    input  TX,
    input  BUSY,
    input  DONE
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FWFT FIFO: one popped word per frame
// (start, WIDTH data bits LSB first, optional parity, 1 or 2 stop bits).
// Frames run back-to-back with no idle gap while the FIFO has data.
module fifo_uart_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic            CLK,
  input logic            RESET_N,
  fifo_uart_tx_if.master bus
);

  localparam int   CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic ODD_PAR  = (PARITY == 2);
  localparam logic LAST_STP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  logic             stop_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic bit_end;
  logic last_stop;
  logic pop;

  // Bit boundary, final stop cycle and the pop strobe (no wait state).
  assign bit_end   = (cnt_q == CW'(CLK_DIV - 1));
  assign last_stop = (state_q == S_STOP) && bit_end && (stop_q == LAST_STP);
  assign pop       = RESET_N && bus.ENABLE && !bus.FIFO_EMPTY &&
                     ((state_q == S_IDLE) || last_stop);

  assign bus.FIFO_READ = pop;
  assign bus.TX        = tx_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

  // Frame sequencer: bit timing, shifting, parity accumulation, registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= bus.FIFO_RDATA;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            par_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BW'(WIDTH - 1)) begin
              if (PARITY != 0) begin
                tx_q    <= par_q ^ ODD_PAR;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
                state_q <= S_STOP;
              end
            end else begin
              bit_q   <= bit_q + BW'(1);
              tx_q    <= shift_q[0];
              par_q   <= par_q ^ shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_q == LAST_STP) begin
              done_q <= 1'b1;
              if (pop) begin
                shift_q <= bus.FIFO_RDATA;
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO models, frame-level reference, UART receiver.
module tb_fifo_uart_tx;

  localparam int DIV    = 4;
  localparam int FRAME0 = (1 + 8 + 0 + 1) * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.WIDTH(8)) if0 ();
  fifo_uart_tx_if #(.WIDTH(8)) if1 ();
  fifo_uart_tx_if #(.WIDTH(8)) if2 ();

  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(clk), .RESET_N(rst_n), .bus(if0.master));
  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(DIV), .PARITY(1), .STOP_BITS(2)) u1 (
    .CLK(clk), .RESET_N(rst_n), .bus(if1.master));
  fifo_uart_tx #(.WIDTH(8), .CLK_DIV(DIV), .PARITY(2), .STOP_BITS(2)) u2 (
    .CLK(clk), .RESET_N(rst_n), .bus(if2.master));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level of frame bit b (0 = start) from the framing rules.
  function automatic logic exp_bit(input logic [7:0] d, input int par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par != 0 && b == 9) return (^d) ^ (par == 2);
    return 1'b1;
  endfunction

  // ---------------- FIFO models (first-word-fall-through) ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         cyc = 0;
  int         pop_cnt = 0;
  int         pop_times[$];
  logic [7:0] pop_word;
  int         pop_cnt1 = 0;
  int         pop_cnt2 = 0;

  always @(posedge clk) begin
    cyc++;
    if (if0.FIFO_READ === 1'b1) begin
      chk("read_nonempty0", if0.FIFO_EMPTY, 0);
      pop_times.push_back(cyc);
      pop_word = if0.FIFO_RDATA;
      pop_cnt++;
      if (q0.size() > 0) void'(q0.pop_front());
    end
    if0.FIFO_EMPTY <= (q0.size() == 0);
    if0.FIFO_RDATA <= (q0.size() > 0) ? q0[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (if1.FIFO_READ === 1'b1) begin
      chk("read_nonempty1", if1.FIFO_EMPTY, 0);
      pop_cnt1++;
      if (q1.size() > 0) void'(q1.pop_front());
    end
    if (if2.FIFO_READ === 1'b1) begin
      chk("read_nonempty2", if2.FIFO_EMPTY, 0);
      pop_cnt2++;
      if (q2.size() > 0) void'(q2.pop_front());
    end
    if1.FIFO_EMPTY <= (q1.size() == 0);
    if1.FIFO_RDATA <= (q1.size() > 0) ? q1[0] : 8'h00;
    if2.FIFO_EMPTY <= (q2.size() == 0);
    if2.FIFO_RDATA <= (q2.size() > 0) ? q2[0] : 8'h00;
  end

  // ---------------- Frame reference for u0 ----------------
  int         m_cyc = 0;
  bit         m_act = 0;
  int         m_seen = 0;
  logic [7:0] m_word = 8'h00;
  logic       m_done;
  int         done_times[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act  = 0;
      m_seen = pop_cnt;
    end else begin
      m_done = m_act && (m_cyc == FRAME0);
      if (m_done) m_act = 0;
      if (m_seen != pop_cnt) begin
        m_seen = pop_cnt;
        m_act  = 1;
        m_cyc  = 0;
        m_word = pop_word;
      end
      chk("done_pulse", if0.DONE, m_done);
      if (if0.DONE === 1'b1) done_times.push_back(cyc);
      if (m_act) begin
        chk("tx_frame", if0.TX, exp_bit(m_word, 0, m_cyc / DIV));
        chk("busy_frame", if0.BUSY, 1);
        m_cyc++;
      end else begin
        chk("tx_idle", if0.TX, 1);
        chk("busy_idle", if0.BUSY, 0);
      end
    end
  end

  // ---------------- Bit-level UART receiver on u0 ----------------
  bit         rx_on = 0;
  bit         rx_busy = 0;
  int         rx_t = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] sent[$];

  always @(negedge clk) begin
    if (!rx_on || !rst_n) begin
      rx_busy = 0;
    end else if (rx_busy) begin
      rx_t++;
      if ((rx_t % DIV) == DIV / 2 && rx_t / DIV >= 1 && rx_t / DIV <= 8)
        rx_byte[rx_t / DIV - 1] = if0.TX;
      if (rx_t == 9 * DIV + DIV / 2) begin
        chk("rx_stop", if0.TX, 1);
        if (sent.size() > 0) chk("rx_byte", rx_byte, sent.pop_front());
        else chk("rx_extra", 1, 0);
        rx_cnt++;
        rx_busy = 0;
      end
    end else if (if0.TX === 1'b0) begin
      rx_busy = 1;
      rx_t    = 0;
    end
  end

  task automatic push0(input logic [7:0] b);
    q0.push_back(b);
    if (rx_on) sent.push_back(b);
  endtask

  // ---------------- Directed + random sequence ----------------
  int   n0;
  int   d0;
  int   p0;
  int   stop_hi;
  int   pushed;
  bit   ok;
  logic [7:0] rb;

  initial begin
    if0.ENABLE = 1'b0;
    if1.ENABLE = 1'b1;
    if2.ENABLE = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", if0.TX, 1);
    chk("rst_busy", if0.BUSY, 0);
    chk("rst_done", if0.DONE, 0);
    chk("rst_read", if0.FIFO_READ, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single 0x55 frame
    if0.ENABLE = 1'b1;
    n0 = pop_cnt;
    push0(8'h55);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pop_cnt != n0) begin ok = 1; break; end
    end
    chk("t1_pop_seen", ok, 1);
    for (int k = 0; k < FRAME0; k++) begin
      if ((k % DIV) == DIV / 2) chk("t1_bit", if0.TX, (k / DIV) % 2);
      @(negedge clk);
    end
    chk("t1_done", if0.DONE, 1);
    chk("t1_pops", pop_cnt - n0, 1);
    @(negedge clk);
    chk("t1_busy_after", if0.BUSY, 0);

    // Test 2: three back-to-back frames
    n0 = pop_times.size();
    d0 = done_times.size();
    push0(8'h01); @(negedge clk);
    push0(8'h02); @(negedge clk);
    push0(8'h03);
    for (int i = 0; i < 400 && done_times.size() < d0 + 3; i++) @(negedge clk);
    chk("t2_dones", done_times.size() - d0, 3);
    chk("t2_pops", pop_times.size() - n0, 3);
    if (pop_times.size() >= n0 + 3 && done_times.size() >= d0 + 3) begin
      chk("t2_gap1", pop_times[n0+1] - pop_times[n0], 40);
      chk("t2_gap2", pop_times[n0+2] - pop_times[n0+1], 40);
      chk("t2_span", done_times[d0+2] - pop_times[n0], 120);
    end

    // Test 3: even / odd parity with two stop bits
    q1.push_back(8'h07);
    q2.push_back(8'h07);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pop_cnt1 > 0) begin ok = 1; break; end
    end
    chk("t3_pop_seen", ok, 1);
    chk("t3_pop_same", pop_cnt2, 1);
    stop_hi = 0;
    for (int k = 0; k < 48; k++) begin
      chk("t3_even_bit", if1.TX, exp_bit(8'h07, 1, k / DIV));
      chk("t3_odd_bit", if2.TX, exp_bit(8'h07, 2, k / DIV));
      if (k == 9 * DIV + 1) begin
        chk("t3_par_even", if1.TX, 1);
        chk("t3_par_odd", if2.TX, 0);
      end
      if (k >= 40 && if1.TX === 1'b1 && if2.TX === 1'b1) stop_hi++;
      @(negedge clk);
    end
    chk("t3_stop_cycles", stop_hi, 8);
    chk("t3_done_even", if1.DONE, 1);
    chk("t3_done_odd", if2.DONE, 1);

    // Test 4: ENABLE gating
    @(negedge clk);
    if0.ENABLE = 1'b0;
    push0(8'hA5);
    n0 = pop_cnt;
    repeat (6) begin
      @(negedge clk);
      chk("t4_no_read", if0.FIFO_READ, 0);
      chk("t4_tx_idle", if0.TX, 1);
    end
    if0.ENABLE = 1'b1;
    #1;
    chk("t4_read_now", if0.FIFO_READ, 1);
    @(negedge clk);
    chk("t4_pop_edge", pop_cnt - n0, 1);
    chk("t4_tx_start", if0.TX, 0);
    chk("t4_word", pop_word, 8'hA5);
    push0(8'h3C);
    repeat (10) @(negedge clk);
    if0.ENABLE = 1'b0;
    for (int i = 0; i < 100 && if0.DONE !== 1'b1; i++) @(negedge clk);
    chk("t4_done", if0.DONE, 1);
    repeat (5) @(negedge clk);
    chk("t4_single_pop", pop_cnt - n0, 1);
    chk("t4_busy_off", if0.BUSY, 0);

    // Test 5: reset mid-frame abandons the word
    push0(8'h96);
    if0.ENABLE = 1'b1;
    n0 = pop_cnt;
    for (int i = 0; i < 10 && pop_cnt == n0; i++) @(negedge clk);
    chk("t5_pop_first", pop_word, 8'h3C);
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", if0.TX, 1);
    chk("t5_rst_busy", if0.BUSY, 0);
    chk("t5_rst_read", if0.FIFO_READ, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = pop_cnt;
    for (int i = 0; i < 10 && pop_cnt == n0; i++) @(negedge clk);
    chk("t5_next_word", pop_word, 8'h96);
    for (int i = 0; i < 100 && if0.DONE !== 1'b1; i++) @(negedge clk);
    chk("t5_done", if0.DONE, 1);

    // Test 6: random fill/drain against the receiver
    @(negedge clk);
    rx_on  = 1;
    pushed = 0;
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < $urandom_range(0, 3); j++) begin
        rb = 8'($urandom);
        push0(rb);
        pushed++;
        @(negedge clk);
      end
      if0.ENABLE = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    if0.ENABLE = 1'b1;
    ok = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && if0.BUSY === 1'b0 && !rx_busy) begin ok = 1; break; end
    end
    chk("t6_drained", ok, 1);
    chk("t6_rx_count", rx_cnt, pushed);
    chk("t6_rx_left", sent.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
